// File: rtl/joy2quad_multi.sv
// Multi-channel joystick-to-quadrature stepper with per-channel acceleration.
// Each channel turns a left/right request into Gray-coded A/B steps at a programmable rate.
module joy2quad_multi #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned DIV_W           = 16,
    parameter int unsigned ACCEL_LEVELS    = 4,
    parameter int unsigned STEPS_PER_LEVEL = 8,
    localparam int unsigned LVL_W          = (ACCEL_LEVELS > 1) ? $clog2(ACCEL_LEVELS) : 1
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [DIV_W-1:0]          clkdiv,
    input  logic                      accel_en,
    input  logic [CHANNELS-1:0]       left,
    input  logic [CHANNELS-1:0]       right,
    output logic [2*CHANNELS-1:0]     steer,
    output logic [CHANNELS-1:0]       moving,
    output logic [CHANNELS*LVL_W-1:0] level
);

    localparam int unsigned STEP_W = $clog2(STEPS_PER_LEVEL + 1);

    localparam logic [1:0]        DIR_IDLE  = 2'd0;
    localparam logic [1:0]        DIR_FWD   = 2'd1;
    localparam logic [1:0]        DIR_REV   = 2'd2;
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(ACCEL_LEVELS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_LEVEL - 1);

    logic [1:0]        phase_q  [CHANNELS];
    logic [1:0]        phase_d  [CHANNELS];
    logic [DIV_W-1:0]  cnt_q    [CHANNELS];
    logic [DIV_W-1:0]  cnt_d    [CHANNELS];
    logic [STEP_W-1:0] steps_q  [CHANNELS];
    logic [STEP_W-1:0] steps_d  [CHANNELS];
    logic [LVL_W-1:0]  level_q  [CHANNELS];
    logic [LVL_W-1:0]  level_d  [CHANNELS];
    logic [1:0]        dir_q    [CHANNELS];
    logic [1:0]        dir_d    [CHANNELS];
    logic              moving_q [CHANNELS];
    logic              moving_d [CHANNELS];

    // Countdown reload value: max(1, div >> lvl) - 1
    function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] div,
                                                    input logic [LVL_W-1:0] lvl);
        logic [DIV_W-1:0] p;
        p = div >> lvl;
        return (p == '0) ? '0 : p - DIV_W'(1);
    endfunction

    // One Gray step on (A,B): convert to binary index, add/subtract, convert back
    function automatic logic [1:0] gray_step(input logic [1:0] ph, input logic fwd);
        logic [1:0] idx;
        idx = {ph[1], ph[1] ^ ph[0]};
        idx = fwd ? idx + 2'd1 : idx - 2'd1;
        return {idx[1], idx[1] ^ idx[0]};
    endfunction

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                phase_q[i]  <= 2'b00;
                cnt_q[i]    <= '0;
                steps_q[i]  <= '0;
                level_q[i]  <= '0;
                dir_q[i]    <= DIR_IDLE;
                moving_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                phase_q[i]  <= phase_d[i];
                cnt_q[i]    <= cnt_d[i];
                steps_q[i]  <= steps_d[i];
                level_q[i]  <= level_d[i];
                dir_q[i]    <= dir_d[i];
                moving_q[i] <= moving_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            phase_d[i]  = phase_q[i];
            cnt_d[i]    = cnt_q[i];
            steps_d[i]  = steps_q[i];
            level_d[i]  = level_q[i];
            moving_d[i] = 1'b0;
            if (right[i] && !left[i])      dir_d[i] = DIR_FWD;
            else if (left[i] && !right[i]) dir_d[i] = DIR_REV;
            else                           dir_d[i] = DIR_IDLE;

            if (dir_d[i] == DIR_IDLE) begin
                cnt_d[i]   = '0;
                steps_d[i] = '0;
                level_d[i] = '0;
            end else if (dir_d[i] != dir_q[i]) begin
                // New press or reversal: restart at level 0 without stepping
                steps_d[i]  = '0;
                level_d[i]  = '0;
                cnt_d[i]    = reload_val(clkdiv, '0);
                moving_d[i] = 1'b1;
            end else begin
                moving_d[i] = 1'b1;
                if (!accel_en) begin
                    steps_d[i] = '0;
                    level_d[i] = '0;
                end
                if (cnt_q[i] == '0) begin
                    phase_d[i] = gray_step(phase_q[i], dir_q[i] == DIR_FWD);
                    if (accel_en) begin
                        if (steps_q[i] == STEP_LAST) begin
                            steps_d[i] = '0;
                            if (level_q[i] != LVL_MAX) level_d[i] = level_q[i] + LVL_W'(1);
                        end else begin
                            steps_d[i] = steps_q[i] + STEP_W'(1);
                        end
                    end
                    // A level raised on this step already shortens this reload
                    cnt_d[i] = reload_val(clkdiv, level_d[i]);
                end else begin
                    cnt_d[i] = cnt_q[i] - DIV_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            steer[2*i +: 2]         = phase_q[i];
            moving[i]               = moving_q[i];
            level[i*LVL_W +: LVL_W] = level_q[i];
        end
    end

endmodule

// File: tb/tb_joy2quad_multi.sv
// Bench for joy2quad_multi: directed scenarios plus random stimulus against a
// time-stamp based reference model (next-step cycle per channel).
module tb_joy2quad_multi;

    localparam int unsigned CH  = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned AL  = 4;
    localparam int unsigned SPL = 8;
    localparam int unsigned LW  = 2;

    logic             CLK = 1'b0;
    logic             reset;
    logic [DW-1:0]    clkdiv;
    logic             accel_en;
    logic [CH-1:0]    left;
    logic [CH-1:0]    right;
    logic [2*CH-1:0]  steer;
    logic [CH-1:0]    moving;
    logic [CH*LW-1:0] level;

    joy2quad_multi #(
        .CHANNELS(CH), .DIV_W(DW), .ACCEL_LEVELS(AL), .STEPS_PER_LEVEL(SPL)
    ) dut (
        .CLK(CLK), .reset(reset), .clkdiv(clkdiv), .accel_en(accel_en),
        .left(left), .right(right), .steer(steer), .moving(moving), .level(level)
    );

    always #5 CLK = ~CLK;

    // Reference model: phase index, level, steps since last level change,
    // absolute cycle of the next step, previous direction (0 idle, 1 fwd, 2 rev)
    int   m_ph [CH];
    int   m_lvl[CH];
    int   m_stp[CH];
    int   m_nxt[CH];
    int   m_dir[CH];
    bit   m_mov[CH];
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic [1:0] gray_tab[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int period(input int l);
        int p;
        p = int'(clkdiv) >> l;
        return (p < 1) ? 1 : p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_ph[i] = 0; m_lvl[i] = 0; m_stp[i] = 0;
            m_nxt[i] = 0; m_dir[i] = 0; m_mov[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int d;
        cyc++;
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < CH; i++) begin
            d = (right[i] && !left[i]) ? 1 : (left[i] && !right[i]) ? 2 : 0;
            if (d == 0) begin
                m_mov[i] = 1'b0; m_lvl[i] = 0; m_stp[i] = 0; m_dir[i] = 0;
            end else if (d != m_dir[i]) begin
                m_dir[i] = d; m_lvl[i] = 0; m_stp[i] = 0; m_mov[i] = 1'b1;
                m_nxt[i] = cyc + period(0);
            end else begin
                m_mov[i] = 1'b1;
                if (!accel_en) begin
                    m_lvl[i] = 0; m_stp[i] = 0;
                end
                if (cyc == m_nxt[i]) begin
                    m_ph[i] = (m_ph[i] + ((d == 1) ? 1 : 3)) % 4;
                    if (accel_en) begin
                        m_stp[i]++;
                        if (m_stp[i] == SPL) begin
                            m_stp[i] = 0;
                            if (m_lvl[i] < AL - 1) m_lvl[i]++;
                        end
                    end
                    m_nxt[i] = cyc + period(m_lvl[i]);
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [2*CH-1:0]  e_steer;
        logic [CH-1:0]    e_mov;
        logic [CH*LW-1:0] e_lvl;
        for (int i = 0; i < CH; i++) begin
            e_steer[2*i +: 2] = gray_tab[m_ph[i]];
            e_mov[i]          = m_mov[i];
            e_lvl[i*LW +: LW] = LW'(m_lvl[i]);
        end
        check("steer", 32'(steer), 32'(e_steer));
        check("moving", 32'(moving), 32'(e_mov));
        check("level", 32'(level), 32'(e_lvl));
    endtask

    // Clock edge, model update, then compare on the falling edge
    task automatic step_cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; left = '0; right = '0;
        step_cycle();
        reset = 1'b0;
    endtask

    initial begin
        gray_tab[0] = 2'b00; gray_tab[1] = 2'b01; gray_tab[2] = 2'b11; gray_tab[3] = 2'b10;
        n_checks = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; clkdiv = DW'(4); accel_en = 1'b0; left = '0; right = '0;
        model_reset();
        #1;
        check("reset_steer", 32'(steer), 32'd0);
        step_cycle();
        step_cycle();
        reset = 1'b0;

        // Basic forward stepping, clkdiv=4
        right = 2'b01;
        for (int k = 0; k <= 20; k++) begin
            step_cycle();
            if (k == 3)  check("fwd_pre", 32'(steer[1:0]), 32'd0);
            if (k == 4)  check("fwd_q1", 32'(steer[1:0]), 32'd1);
            if (k == 8)  check("fwd_q2", 32'(steer[1:0]), 32'd3);
            if (k == 12) check("fwd_q3", 32'(steer[1:0]), 32'd2);
            if (k == 16) check("fwd_q0", 32'(steer[1:0]), 32'd0);
            if (k == 20) check("fwd_wrap", 32'(steer[1:0]), 32'd1);
        end
        check("fwd_ch1_idle", 32'(steer[3:2]), 32'd0);

        // Reversal at Q2 with clkdiv=3
        do_reset();
        clkdiv = DW'(3); right = 2'b01;
        for (int k = 0; k < 7; k++) step_cycle();
        check("rev_at_q2", 32'(steer[1:0]), 32'd3);
        right = 2'b00; left = 2'b01;
        for (int k = 0; k <= 6; k++) begin
            step_cycle();
            if (k == 0) check("rev_hold", 32'(steer[1:0]), 32'd3);
            if (k == 2) check("rev_pre", 32'(steer[1:0]), 32'd3);
            if (k == 3) check("rev_q1", 32'(steer[1:0]), 32'd1);
            if (k == 6) check("rev_q0", 32'(steer[1:0]), 32'd0);
        end

        // Both pressed, then release one
        left = 2'b01; right = 2'b01;
        for (int k = 0; k < 10; k++) step_cycle();
        check("both_moving", 32'(moving), 32'd0);
        left = 2'b00;
        for (int k = 0; k < 8; k++) step_cycle();

        // Acceleration on channel 1
        do_reset();
        clkdiv = DW'(16); accel_en = 1'b1; right = 2'b10;
        for (int k = 0; k < 240; k++) begin
            step_cycle();
            if (k == 127) check("acc_lvl0", 32'(level[3:2]), 32'd0);
            if (k == 128) check("acc_lvl1", 32'(level[3:2]), 32'd1);
            if (k == 192) check("acc_lvl2", 32'(level[3:2]), 32'd2);
            if (k == 224) check("acc_lvl3", 32'(level[3:2]), 32'd3);
        end
        check("acc_sat", 32'(level[3:2]), 32'd3);
        right = 2'b00;
        step_cycle();
        check("acc_release", 32'(level[3:2]), 32'd0);
        accel_en = 1'b0;

        // Edge periods 0 and 1 step every cycle
        for (int dv = 0; dv < 2; dv++) begin
            do_reset();
            clkdiv = DW'(dv); right = 2'b01;
            for (int k = 0; k <= 4; k++) begin
                step_cycle();
                if (k >= 1) check("fast_step", 32'(steer[1:0]), 32'(gray_tab[k % 4]));
            end
        end

        // Asynchronous reset mid-run at Q2
        do_reset();
        clkdiv = DW'(3); right = 2'b01;
        for (int k = 0; k < 7; k++) step_cycle();
        #2 reset = 1'b1;
        #1;
        check("async_steer", 32'(steer), 32'd0);
        check("async_moving", 32'(moving), 32'd0);
        check("async_level", 32'(level), 32'd0);
        model_reset();
        step_cycle();
        reset = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            step_cycle();
            if (k == 2) check("post_rst_pre", 32'(steer[1:0]), 32'd0);
            if (k == 3) check("post_rst_q1", 32'(steer[1:0]), 32'd1);
        end

        // Random stimulus against the model
        clkdiv = DW'(2);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 15) == 0) {left[i], right[i]} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0)  clkdiv = DW'($urandom_range(0, 9));
            if ($urandom_range(0, 127) == 0) accel_en = ~accel_en;
            step_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/joy2quad_multi.md
JOY2QUAD_MULTI -- requirements
Module: joy2quad_multi

Interface
REQ-001 The block SHALL expose the following parameters:
- CHANNELS, default 2, number of independent steering channels.
- DIV_W, default 16, width of the rate divider.
- ACCEL_LEVELS, default 4, number of acceleration levels (1 disables acceleration).
- STEPS_PER_LEVEL, default 8, consecutive same-direction steps before the level rises.

REQ-002 The block SHALL have the following ports:
- CLK  in  1  single system clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high.
- clkdiv  in  DIV_W  base step period in CLK cycles, shared by all channels.
- accel_en  in  1  1 = acceleration active.
- left  in  CHANNELS  per-channel left request, active-high.
- right  in  CHANNELS  per-channel right request, active-high.
- steer  out  2*CHANNELS  quadrature outputs; steer[2i+1] = A(i), steer[2i] = B(i).
- moving  out  CHANNELS  1 while channel i is actively stepping.
- level  out  CHANNELS*clog2(ACCEL_LEVELS), min width 1  current acceleration level per channel.

Function
REQ-003 Each channel SHALL be fully independent, with its own phase, countdown, step count, level and previous-direction state.
REQ-004 Direction per channel SHALL be decoded as follows:
- right only: FWD.
- left only: REV.
- neither, or both: IDLE.
REQ-005 The phase state SHALL follow the Gray code Q0=00, Q1=01, Q2=11, Q3=10 on (A,B).
- FWD steps Q0->Q1->Q2->Q3->Q0.
- REV steps in the opposite order.
REQ-006 The effective period SHALL be max(1, clkdiv >> level), evaluated when the countdown is loaded.
REQ-007 When the direction changes from IDLE or the opposite direction into FWD or REV, the countdown SHALL be loaded with (period-1) on that edge, with no phase change.
REQ-008 While the direction is unchanged and non-IDLE, the countdown SHALL decrement each cycle.
- At 0, the phase advances one step on the same edge and the countdown reloads (period-1).
- First step lands exactly period cycles after the press edge.
REQ-009 In IDLE, phase SHALL hold, the countdown SHALL hold at 0, and moving SHALL be 0.
REQ-010 moving(i) SHALL be registered and equal 1 on every cycle after the edge that loaded the countdown while the direction stays non-IDLE.
REQ-011 Acceleration with accel_en=1 SHALL work as follows:
- The step count increments on each phase step.
- On reaching STEPS_PER_LEVEL, the step count clears and level increments, saturating at ACCEL_LEVELS-1.
REQ-012 Level and step count SHALL clear to 0 on IDLE, on direction reversal, or whenever accel_en=0.
- The new level applies from the next countdown load.
REQ-013 A reversal SHALL not emit an extra step: phase holds on the reversal edge and the first REV step follows a full level-0 period.
REQ-014 A clkdiv change mid-operation SHALL take effect at the next countdown load; the current countdown is not truncated.
REQ-015 No combinational path SHALL exist from left/right/clkdiv to steer, moving or level.
REQ-016 Phase state SHALL wrap modulo 4 without limit; no positional counter exists.

Reset
REQ-017 While reset=1, for every channel:
- phase = Q0, so steer is all 0.
- countdown = 0, step count = 0, level = 0, moving = 0.
- Previous direction = IDLE.
REQ-018 Reset assertion SHALL take effect immediately and asynchronously, including mid-step.
REQ-019 After reset deasserts, a held direction SHALL be treated as a new press: load on the first clock edge, first step one period later.

Verification
REQ-020 Basic FWD stepping: CHANNELS=2, clkdiv=4, accel_en=0, right[0] held 20 cycles.
- steer[1:0] takes 01 at cycle 4, 11 at 8, 10 at 12, 00 at 16, 01 at 20.
- steer[3:2] stays 00.
REQ-021 REV with reversal: clkdiv=3, right[0] for 7 cycles (two steps, now Q2), then left[0].
- Phase holds at 11 on the switch edge.
- Phase reaches 01 three cycles later, then 00 after three more.
REQ-022 Both pressed / release: left[0]=right[0]=1 for 10 cycles gives no steer change and moving=0. Releasing one button starts a fresh period.
REQ-023 Acceleration: clkdiv=16, accel_en=1, STEPS_PER_LEVEL=8, right[1] held.
- Steps 1-8 spaced 16 cycles, steps 9-16 spaced 8, steps 17-24 spaced 4.
- After that, spacing stays at 2 (level 3 saturated).
- Release returns level to 0.
REQ-024 Edge periods: clkdiv=0 and clkdiv=1 both step every cycle. clkdiv=16 at level 3 steps every 2 cycles.
REQ-025 Async reset mid-run: assert reset at Q2 between clock edges.
- steer goes to 00 and moving/level go to 0 without a clock edge.
- With right held, the first step lands one full period after deassertion.
